link_sync_mon: RTL

- Parametrised successor to the CFEB/CSC fiber sync monitor: checks K-char frame markers on NLINK optical links every cycle and flags any link that is off-marker or disagrees with the others.
- Adds per-link lost-sync latches, a saturating mismatch counter, first-failure capture, programmable marker pair and an explicit resync state machine.
- Sits beside the fiber receivers, feeding status to the VME status registers.

---
 rtl/csc_sync_pkg.sv | 30 +++
 rtl/link_settle_cnt.sv | 37 +++
 rtl/link_sync_mon.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/csc_sync_pkg.sv
// ---------------------------------------------------------------------------
// csc_sync_pkg
// Shared definitions for the fiber link sync monitor:
//   - resync FSM state encoding
//   - default K-char frame markers
//   - maximum supported link count
//   - lowest_index(): priority encoder used for first-failure capture
// ---------------------------------------------------------------------------
package csc_sync_pkg;

   localparam int MAX_LINKS = 16;

   localparam logic [1:0] WAIT_DONE = 2'd0;
   localparam logic [1:0] DELAY     = 2'd1;
   localparam logic [1:0] MONITOR   = 2'd2;

   localparam logic [7:0] KCHAR_IDLE  = 8'hBC;
   localparam logic [7:0] KCHAR_FRAME = 8'hFC;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [3:0] lowest_index(input logic [MAX_LINKS-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = MAX_LINKS - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/link_settle_cnt.sv
// ---------------------------------------------------------------------------
// link_settle_cnt
// Per-link settle counter. A link only takes part in marker checking once its
// receiver has reported link_good for SETTLE consecutive cycles.
// Ports:
//   clock, global_reset : clock, async active-high reset
//   link_good           : receiver link-good for this link
//   fiber_enable        : link enabled for checking
//   checked             : link participates in this cycle's check
// ---------------------------------------------------------------------------
module link_settle_cnt #(
   parameter int SETTLE = 2
) (
   input  logic clock,
   input  logic global_reset,
   input  logic link_good,
   input  logic fiber_enable,
   output logic checked
);

   localparam logic [3:0] SETTLE_MAX = 4'(SETTLE);

   logic [3:0] settle_cnt;

   always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset)
         settle_cnt <= '0;
      else if (!link_good)
         settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX)
         settle_cnt <= settle_cnt + 4'd1;
   end

   // Uses the live link_good so a dropping link is excluded in the same cycle.
   assign checked = fiber_enable & link_good & (settle_cnt == SETTLE_MAX);

endmodule

// File: rtl/link_sync_mon.sv
// ---------------------------------------------------------------------------
// link_sync_mon
// Checks the K-char frame marker on NLINK fiber links every cycle while in
// MONITOR and flags links that are off-marker or disagree with the others.
// Ports:
//   clock, global_reset  : LHC clock, async active-high reset
//   ttc_resync           : restart sync sequence, clear sticky status
//   link_kchar           : K-char per link, link i at [i*KW +: KW]
//   link_good            : receiver link-good per link
//   fiber_enable         : link enabled for checking
//   sync_done            : per-link resync complete
//   sync_delay           : extra holdoff cycles after all sync_done
//   kchar_a, kchar_b     : accepted marker pair
//   cnt_clear            : clears mismatch_cnt and first-failure capture
//   links_synced         : all checked links valid and equal (registered)
//   links_lostsync       : OR of link_lostsync
//   link_lostsync        : sticky per-link failure
//   mismatch_cnt         : saturating count of failing cycles
//   first_bad            : lowest failing link at first failure
//   first_bad_vld        : first_bad holds a capture
//   mon_active           : FSM is in MONITOR
// NLINK must be in 1..MAX_LINKS so the link index fits in first_bad.
// ---------------------------------------------------------------------------
module link_sync_mon
   import csc_sync_pkg::*;
#(
   parameter int NLINK  = 7,
   parameter int KW     = 8,
   parameter int CNTW   = 16,
   parameter int SETTLE = 2
) (
   input  logic                clock,
   input  logic                global_reset,
   input  logic                ttc_resync,
   input  logic [NLINK*KW-1:0] link_kchar,
   input  logic [NLINK-1:0]    link_good,
   input  logic [NLINK-1:0]    fiber_enable,
   input  logic [NLINK-1:0]    sync_done,
   input  logic [3:0]          sync_delay,
   input  logic [KW-1:0]       kchar_a,
   input  logic [KW-1:0]       kchar_b,
   input  logic                cnt_clear,
   output logic                links_synced,
   output logic                links_lostsync,
   output logic [NLINK-1:0]    link_lostsync,
   output logic [CNTW-1:0]     mismatch_cnt,
   output logic [3:0]          first_bad,
   output logic                first_bad_vld,
   output logic                mon_active
);

   logic [1:0]       state;
   logic [3:0]       dly_cnt;
   logic [NLINK-1:0] checked;
   logic [NLINK-1:0] bad;
   logic [KW-1:0]    kchar [NLINK];
   logic [KW-1:0]    k_and;
   logic [KW-1:0]    k_or;
   logic             disagree;
   logic             all_done;
   logic             in_mon;
   logic             fail;
   logic             fail_event;
   logic [3:0]       fail_idx;
   logic [MAX_LINKS-1:0] bad_w;
   logic [MAX_LINKS-1:0] chk_w;

   // ---------------- per-link settle and marker check ----------------
   for (genvar i = 0; i < NLINK; i++) begin : g_link
      link_settle_cnt #(.SETTLE(SETTLE)) u_settle (
         .clock        (clock),
         .global_reset (global_reset),
         .link_good    (link_good[i]),
         .fiber_enable (fiber_enable[i]),
         .checked      (checked[i])
      );
      assign kchar[i] = link_kchar[i*KW +: KW];
      assign bad[i]   = checked[i] & (kchar[i] != kchar_a) & (kchar[i] != kchar_b);
   end

   // All checked links agree exactly when the bitwise AND and OR of their
   // K-chars are identical. With nothing checked the reductions differ
   // trivially, hence the |checked qualifier.
   always_comb begin
      k_and = '1;
      k_or  = '0;
      for (int i = 0; i < NLINK; i++) begin
         if (checked[i]) begin
            k_and = k_and & kchar[i];
            k_or  = k_or  | kchar[i];
         end
      end
   end

   assign disagree = (|checked) & (k_and != k_or);
   assign in_mon   = (state == MONITOR);
   assign fail     = in_mon & ((|bad) | disagree);
   // Resync takes priority, so a failing resync cycle is neither counted
   // nor captured.
   assign fail_event = fail & ~ttc_resync;

   always_comb begin
      bad_w = '0;
      chk_w = '0;
      bad_w[NLINK-1:0] = bad;
      chk_w[NLINK-1:0] = checked;
   end

   assign fail_idx = (|bad) ? lowest_index(bad_w) : lowest_index(chk_w);

   // With no enabled links fall back to requiring every sync_done.
   assign all_done = (|fiber_enable) ? &(sync_done | ~fiber_enable) : &sync_done;

   // ---------------- resync FSM ----------------
   always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
         state   <= WAIT_DONE;
         dly_cnt <= '0;
      end else if (ttc_resync) begin
         state   <= WAIT_DONE;
      end else begin
         case (state)
            WAIT_DONE: begin
               if (all_done) begin
                  dly_cnt <= sync_delay;
                  state   <= DELAY;
               end
            end
            DELAY: begin
               if (dly_cnt == 4'd0)
                  state <= MONITOR;
               else
                  dly_cnt <= dly_cnt - 4'd1;
            end
            MONITOR: state <= MONITOR;
            default: state <= WAIT_DONE;
         endcase
      end
   end

   assign mon_active = in_mon;

   // ---------------- sync status ----------------
   always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
         links_synced  <= 1'b1;
         link_lostsync <= '0;
      end else if (ttc_resync) begin
         links_synced  <= 1'b1;
         link_lostsync <= '0;
      end else if (in_mon) begin
         links_synced  <= ~fail;
         link_lostsync <= link_lostsync | bad | (checked & {NLINK{disagree}});
      end else begin
         links_synced  <= 1'b1;
      end
   end

   assign links_lostsync = |link_lostsync;

   // ---------------- mismatch counter and first-failure capture ----------------
   always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
         mismatch_cnt  <= '0;
         first_bad     <= '0;
         first_bad_vld <= 1'b0;
      end else if (cnt_clear) begin
         mismatch_cnt  <= '0;
         first_bad     <= '0;
         first_bad_vld <= 1'b0;
      end else if (fail_event) begin
         if (mismatch_cnt != '1)
            mismatch_cnt <= mismatch_cnt + CNTW'(1);
         if (!first_bad_vld) begin
            first_bad     <= fail_idx;
            first_bad_vld <= 1'b1;
         end
      end
   end

endmodule
